cyclic_retire_tracker: RTL and testbench
========================================

// Module: cyclic_retire_tracker
// PURPOSE
//  Owns the head/tail pointers of a cyclic WIDTH-slot tracking array, i.e. the allocating/retiring counterpart of a head/tail-to-mask decoder.
//  Allocates slots in order at tail. Accepts out-of-order completion per slot. Each cycle, retires the longest contiguous run of completed slots starting at head.
//  Reports the retired run as a cyclic mask plus a count.
//  Sits beside the prefetch/request tables: those index entries by slot and need in-order release with out-of-order completion.
// PARAMETERS
//  LOG_WIDTH  3            log2 of slot count
//  WIDTH      1<<LOG_WIDTH number of slots (derived; do not override)
// PORTS
//  clk           in   1            clock, all state on rising edge
//  rst           in   1            synchronous, active-high reset
//  flush         in   1            synchronous clear of all slots
//  alloc_valid   in   1            request to allocate one slot at tail
//  alloc_ready   out  1            !full; an alloc is accepted when valid&&ready
//  alloc_idx     out  LOG_WIDTH    slot index granted (= tail_idx)
//  done_valid    in   1            mark slot done_idx completed
//  done_idx      in   LOG_WIDTH    slot being completed
//  retire_valid  out  1            registered; a non-empty run was retired
//  retire_count  out  LOG_WIDTH+1  registered; slots retired (0..WIDTH)
//  retire_mask   out  WIDTH        registered; cyclic mask of retired slots
//  head_idx      out  LOG_WIDTH    oldest busy slot
//  tail_idx      out  LOG_WIDTH    next slot to allocate
//  occupancy     out  LOG_WIDTH+1  busy slot count
//  full / empty  out  1            occupancy==WIDTH / occupancy==0
// BEHAVIOUR
//  - State: head, tail, occupancy, busy[WIDTH], done[WIDTH], registered retire_* outputs.
//  - Reset (rst=1): head=tail=0, occupancy=0, busy=done=0, retire_valid=0, retire_count=0, retire_mask=0.
//    Outputs follow: empty=1, full=0, alloc_ready=1.
//  - rst has priority over flush. flush has the same effect as rst.
//    flush also overrides alloc and done in the same cycle; an alloc presented with flush is not accepted.
//  - head==tail is ambiguous (empty or full). Only occupancy disambiguates it. All flags derive from occupancy.
//  - Alloc, when alloc_valid && !full:
//    - busy[tail]<=1, done[tail]<=0.
//    - tail<=tail+1, mod WIDTH, natural wrap.
//    - alloc_idx is the pre-increment tail.
//  - Done, when done_valid && busy[done_idx]: done[done_idx]<=1.
//    Done on a non-busy slot is silently ignored, including a slot being allocated or retired the same cycle.
//    Repeated done on a slot is idempotent.
//  - Retire is computed from current registered state:
//    - rdy = busy & done.
//    - Rotate rdy right by head.
//    - n = number of trailing ones (0..WIDTH).
//    - run = (n ones) rotated left by head.
//    On the edge:
//    - busy[run]<=0, done[run]<=0.
//    - head<=head+n, mod WIDTH.
//    - retire_mask<=run, retire_count<=n, retire_valid<=(n!=0).
//  - Latency:
//    - Done in cycle N: retired on edge N+1; retire_valid visible in N+2.
//    - Alloc in cycle N: slot busy from N+1.
//  - Retire stops at the first slot that is not (busy&done), so a run never passes tail.
//    n==WIDTH is legal: full and all done gives mask all-ones, head unchanged.
//  - Simultaneous alloc+retire: occupancy<=occupancy+acc-n, computed at LOG_WIDTH+1 bits, never out of range.
//    Full/alloc_ready use pre-edge occupancy, so a slot freed this cycle is allocatable next cycle (no bypass).
//  - retire_* outputs are single-cycle pulses. They return to 0 when the next cycle retires nothing.
// STRUCTURE
//  - Shared package cyclic_ptr_pkg: function rot_r / rot_l (WIDTH-generic), trailing_ones count function.
//    The existing mask generator and this block both use it.
//  - One combinational sub-module: cyclic_run_finder.
//    Inputs: rdy[WIDTH], head. Outputs: n, run.
//    Implements rotate, count trailing ones, and rotate back.
//    The top keeps all sequential state.
// TESTING (WIDTH=8)
//  1 Reset/flush -> head=tail=0, occupancy=0, empty=1, full=0, alloc_ready=1, retire_valid=0.
//  2 Alloc 3 (idx 0,1,2), then done 2 -> no retire. Then done 0 -> retire_count=1, retire_mask=8'h01, head=1.
//    Then done 1 -> count=2, mask=8'h06, head=3, empty=1.
//  3 Alloc 8 -> full=1, alloc_ready=0, head=tail=0, occupancy=8.
//    Extra alloc_valid ignored. Done all 8 same cycle -> count=8, mask=8'hFF, empty=1.
//  4 Wrap: head=6 with slots 6,7,0,1 busy. Done all four -> count=4, mask=8'hC3, head=2.
//  5 Done on idle slot 5, and done+flush same cycle -> no state change / everything cleared.
//    Alloc while full with a retire the same cycle -> refused this cycle, accepted next.
//  6 Random alloc/done stress against a reference queue model.
//    Check in-order retire, mask==count, occupancy invariant.

Source files
------------

// File: rtl/cyclic_ptr_pkg.sv
// rtl/cyclic_ptr_pkg.sv - cyclic pointer helpers shared by the slot-mask blocks
// Purpose: slot-array geometry plus rotate and trailing-ones helpers used by
//          the retire tracker and the head/tail mask generator.
// Ports:   none (package).
package cyclic_ptr_pkg;

  localparam int LOG_WIDTH = 3;
  localparam int WIDTH     = 1 << LOG_WIDTH;

  typedef logic [WIDTH-1:0]     slot_mask_t;
  typedef logic [LOG_WIDTH-1:0] slot_idx_t;
  typedef logic [LOG_WIDTH:0]   slot_cnt_t;

  // Rotate right by sh: bit sh of v lands in bit 0.
  function automatic slot_mask_t rot_r(input slot_mask_t v, input slot_idx_t sh);
    return (v >> sh) | (v << (WIDTH - int'(sh)));
  endfunction

  // Rotate left by sh: bit 0 of v lands in bit sh.
  function automatic slot_mask_t rot_l(input slot_mask_t v, input slot_idx_t sh);
    return (v << sh) | (v >> (WIDTH - int'(sh)));
  endfunction

  // Mask with the n lowest bits set (n in 0..WIDTH).
  function automatic slot_mask_t low_ones(input slot_cnt_t n);
    slot_mask_t m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  // Number of consecutive ones starting at bit 0 (0..WIDTH).
  function automatic slot_cnt_t trailing_ones(input slot_mask_t v);
    slot_cnt_t n;
    logic      run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & v[i];
      if (run) n = n + slot_cnt_t'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/cyclic_retire_tracker_if.sv
// rtl/cyclic_retire_tracker_if.sv - alloc/done/retire/status bundle of the retire tracker
// Purpose: groups the tracker's request and status signals.
// Ports:   master drives flush, alloc_valid, done_valid, done_idx and observes
//          alloc_ready, alloc_idx, retire_*, head_idx, tail_idx, occupancy,
//          full, empty; slave is the tracker side.
interface cyclic_retire_tracker_if;
  import cyclic_ptr_pkg::*;

  logic       flush;
  logic       alloc_valid;
  logic       alloc_ready;
  slot_idx_t  alloc_idx;
  logic       done_valid;
  slot_idx_t  done_idx;
  logic       retire_valid;
  slot_cnt_t  retire_count;
  slot_mask_t retire_mask;
  slot_idx_t  head_idx;
  slot_idx_t  tail_idx;
  slot_cnt_t  occupancy;
  logic       full;
  logic       empty;

  modport master (
    output flush, alloc_valid, done_valid, done_idx,
    input  alloc_ready, alloc_idx, retire_valid, retire_count, retire_mask,
           head_idx, tail_idx, occupancy, full, empty
  );

  modport slave (
    input  flush, alloc_valid, done_valid, done_idx,
    output alloc_ready, alloc_idx, retire_valid, retire_count, retire_mask,
           head_idx, tail_idx, occupancy, full, empty
  );

endinterface

// File: rtl/cyclic_run_finder.sv
// rtl/cyclic_run_finder.sv - longest ready run starting at head, as count and cyclic mask
// Purpose: combinational; rotates rdy so head sits at bit 0, counts trailing
//          ones, and rotates the resulting run mask back into slot order.
// Ports:   rdy  in  WIDTH        busy&done per slot
//          head in  LOG_WIDTH    oldest busy slot
//          n    out LOG_WIDTH+1  run length (0..WIDTH)
//          run  out WIDTH        cyclic mask of the run
module cyclic_run_finder
  import cyclic_ptr_pkg::*;
(
  input  slot_mask_t rdy,
  input  slot_idx_t  head,
  output slot_cnt_t  n,
  output slot_mask_t run
);

  slot_mask_t rdy_rot;

  always_comb begin
    rdy_rot = rot_r(rdy, head);
    n       = trailing_ones(rdy_rot);
    run     = rot_l(low_ones(n), head);
  end

endmodule

// File: rtl/cyclic_retire_tracker.sv
// rtl/cyclic_retire_tracker.sv - in-order retire of out-of-order completed cyclic slots
// Purpose: allocates slots at tail, records per-slot completion, and each
//          cycle retires the contiguous completed run starting at head.
// Ports:   clk  in  clock, all state on rising edge
//          rst  in  synchronous active-high reset
//          bus  slave modport: flush, alloc handshake, done, registered
//               retire pulse, head/tail/occupancy/full/empty status
module cyclic_retire_tracker
  import cyclic_ptr_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  cyclic_retire_tracker_if.slave  bus
);

  slot_mask_t busy, done;
  slot_mask_t busy_nx, done_nx;
  slot_mask_t rdy, run;
  slot_idx_t  head, tail;
  slot_cnt_t  occupancy, n;
  logic       full;
  logic       acc;
  logic       done_ok;
  logic       ret_valid;
  slot_cnt_t  ret_count;
  slot_mask_t ret_mask;

  // head==tail is ambiguous, so every flag comes from occupancy.
  assign full    = (occupancy == slot_cnt_t'(WIDTH));
  assign acc     = bus.alloc_valid && !full;
  assign done_ok = bus.done_valid && busy[bus.done_idx];
  assign rdy     = busy & done;

  cyclic_run_finder u_run_finder (
    .rdy  (rdy),
    .head (head),
    .n    (n),
    .run  (run)
  );

  // Done lands before the run clear, so a done on a retiring slot vanishes
  // with it. The alloc slot is never busy (or full blocks the alloc), so it
  // cannot collide with the done or the run.
  always_comb begin
    busy_nx = busy & ~run;
    done_nx = done;
    if (done_ok) done_nx[bus.done_idx] = 1'b1;
    done_nx = done_nx & ~run;
    if (acc) begin
      busy_nx[tail] = 1'b1;
      done_nx[tail] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      busy      <= '0;
      done      <= '0;
      ret_valid <= 1'b0;
      ret_count <= '0;
      ret_mask  <= '0;
    end else begin
      busy      <= busy_nx;
      done      <= done_nx;
      head      <= head + n[LOG_WIDTH-1:0];
      if (acc) tail <= tail + slot_idx_t'(1);
      occupancy <= occupancy + slot_cnt_t'(acc) - n;
      ret_valid <= (n != '0);
      ret_count <= n;
      ret_mask  <= run;
    end
  end

  assign bus.alloc_ready  = !full;
  assign bus.alloc_idx    = tail;
  assign bus.retire_valid = ret_valid;
  assign bus.retire_count = ret_count;
  assign bus.retire_mask  = ret_mask;
  assign bus.head_idx     = head;
  assign bus.tail_idx     = tail;
  assign bus.occupancy    = occupancy;
  assign bus.full         = full;
  assign bus.empty        = (occupancy == '0);

endmodule

// File: tb/tb_cyclic_retire_tracker.sv
// tb/tb_cyclic_retire_tracker.sv - scoreboard bench for cyclic_retire_tracker
module tb_cyclic_retire_tracker;

  typedef struct {
    int cnt;
    int mask;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  exp_t sb[$];
  int   order[$];
  bit   m_busy[8];
  bit   m_done[8];
  int   m_head;
  int   m_tail;

  cyclic_retire_tracker_if bus ();

  cyclic_retire_tracker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    order.delete();
    for (int i = 0; i < 8; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
    end
    m_head = 0;
    m_tail = 0;
  endtask

  // One clock: drive inputs, advance the reference queue, check after the edge.
  task automatic step(input bit av, input bit dv, input int di, input bit fl);
    exp_t e;
    int   n;
    int   mask;
    bit   acc;
    bus.alloc_valid = av;
    bus.done_valid  = dv;
    bus.done_idx    = 3'(di);
    bus.flush       = fl;
    #1;
    if (av && !fl && order.size() < 8) begin
      vectors++;
      if (bus.alloc_idx !== 3'(m_tail)) begin
        miscompares++;
        $display("FAIL alloc_idx: got %0d expected %0d", bus.alloc_idx, m_tail);
      end
    end
    if (fl) begin
      model_clear();
    end else begin
      n = 0;
      mask = 0;
      while (n < order.size() && m_done[order[n]]) begin
        mask |= (1 << order[n]);
        n++;
      end
      acc = av && (order.size() < 8);
      if (dv && m_busy[di]) m_done[di] = 1;
      repeat (n) begin
        m_busy[order[0]] = 0;
        m_done[order[0]] = 0;
        void'(order.pop_front());
      end
      m_head = (m_head + n) % 8;
      if (acc) begin
        order.push_back(m_tail);
        m_busy[m_tail] = 1;
        m_done[m_tail] = 0;
        m_tail = (m_tail + 1) % 8;
      end
      if (n > 0) begin
        e.cnt  = n;
        e.mask = mask;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.alloc_valid = 0;
    bus.done_valid  = 0;
    bus.flush       = 0;
    vectors++;
    if (bus.retire_valid === 1'b1) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL retire_unexpected: got count=%0d mask=%02h expected no retire", bus.retire_count, bus.retire_mask);
      end else begin
        e = sb.pop_front();
        if (bus.retire_count !== 4'(e.cnt) || bus.retire_mask !== 8'(e.mask) ||
            $countones(bus.retire_mask) != e.cnt) begin
          miscompares++;
          $display("FAIL retire: got count=%0d mask=%02h expected count=%0d mask=%02h",
                   bus.retire_count, bus.retire_mask, e.cnt, e.mask);
        end
      end
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        miscompares++;
        $display("FAIL retire_missing: got retire_valid=%b expected count=%0d mask=%02h",
                 bus.retire_valid, e.cnt, e.mask);
      end else if (bus.retire_count !== 4'd0 || bus.retire_mask !== 8'h00 || bus.retire_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL retire_idle: got valid=%b count=%0d mask=%02h expected 0/0/00",
                 bus.retire_valid, bus.retire_count, bus.retire_mask);
      end
    end
    vectors++;
    if (bus.head_idx !== 3'(m_head) || bus.tail_idx !== 3'(m_tail) ||
        bus.occupancy !== 4'(order.size()) || bus.full !== (order.size() == 8) ||
        bus.empty !== (order.size() == 0) || bus.alloc_ready !== (order.size() != 8)) begin
      miscompares++;
      $display("FAIL status: got head=%0d tail=%0d occ=%0d full=%b empty=%b ready=%b expected head=%0d tail=%0d occ=%0d",
               bus.head_idx, bus.tail_idx, bus.occupancy, bus.full, bus.empty, bus.alloc_ready,
               m_head, m_tail, order.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    bus.alloc_valid = 0;
    bus.done_valid  = 0;
    bus.done_idx    = 0;
    bus.flush       = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    vectors++;
    if (bus.head_idx !== 3'd0 || bus.tail_idx !== 3'd0 || bus.occupancy !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_ptrs: got head=%0d tail=%0d occ=%0d expected 0/0/0", bus.head_idx, bus.tail_idx, bus.occupancy);
    end
    vectors++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.retire_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got empty=%b full=%b ready=%b rv=%b expected 1/0/1/0",
               bus.empty, bus.full, bus.alloc_ready, bus.retire_valid);
    end
  endtask

  task automatic test_basic();
    repeat (3) step(1, 0, 0, 0);
    step(0, 1, 2, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.retire_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_no_retire: got retire_valid=%b expected 0", bus.retire_valid);
    end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.retire_count !== 4'd1 || bus.retire_mask !== 8'h01 || bus.head_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL basic_first: got count=%0d mask=%02h head=%0d expected 1/01/1", bus.retire_count, bus.retire_mask, bus.head_idx);
    end
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.retire_count !== 4'd2 || bus.retire_mask !== 8'h06 || bus.head_idx !== 3'd3 || bus.empty !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_second: got count=%0d mask=%02h head=%0d empty=%b expected 2/06/3/1",
               bus.retire_count, bus.retire_mask, bus.head_idx, bus.empty);
    end
  endtask

  task automatic test_full();
    step(0, 0, 0, 1);
    repeat (8) step(1, 0, 0, 0);
    vectors++;
    if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.head_idx !== 3'd0 ||
        bus.tail_idx !== 3'd0 || bus.occupancy !== 4'd8) begin
      miscompares++;
      $display("FAIL full_flags: got full=%b ready=%b head=%0d tail=%0d occ=%0d expected 1/0/0/0/8",
               bus.full, bus.alloc_ready, bus.head_idx, bus.tail_idx, bus.occupancy);
    end
    step(1, 0, 0, 0);
    for (int i = 1; i < 8; i++) step(0, 1, i, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.retire_count !== 4'd8 || bus.retire_mask !== 8'hFF || bus.empty !== 1'b1 || bus.head_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL full_retire: got count=%0d mask=%02h empty=%b head=%0d expected 8/FF/1/0",
               bus.retire_count, bus.retire_mask, bus.empty, bus.head_idx);
    end
  endtask

  task automatic test_wrap();
    repeat (6) step(1, 0, 0, 0);
    for (int i = 5; i >= 0; i--) step(0, 1, i, 0);
    step(0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    vectors++;
    if (bus.head_idx !== 3'd6 || bus.tail_idx !== 3'd2 || bus.occupancy !== 4'd4) begin
      miscompares++;
      $display("FAIL wrap_setup: got head=%0d tail=%0d occ=%0d expected 6/2/4", bus.head_idx, bus.tail_idx, bus.occupancy);
    end
    step(0, 1, 7, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 6, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.retire_count !== 4'd4 || bus.retire_mask !== 8'hC3 || bus.head_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL wrap_retire: got count=%0d mask=%02h head=%0d expected 4/C3/2", bus.retire_count, bus.retire_mask, bus.head_idx);
    end
  endtask

  task automatic test_edge();
    step(0, 1, 5, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.retire_valid !== 1'b0 || bus.head_idx !== 3'd2) begin
      miscompares++;
      $display("FAIL idle_done: got occ=%0d rv=%b head=%0d expected 0/0/2", bus.occupancy, bus.retire_valid, bus.head_idx);
    end
    repeat (2) step(1, 0, 0, 0);
    step(0, 1, 2, 0);
    step(1, 1, 3, 1);
    vectors++;
    if (bus.occupancy !== 4'd0 || bus.retire_valid !== 1'b0 || bus.tail_idx !== 3'd0 || bus.head_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_done: got occ=%0d rv=%b tail=%0d head=%0d expected 0/0/0/0",
               bus.occupancy, bus.retire_valid, bus.tail_idx, bus.head_idx);
    end
    repeat (8) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    vectors++;
    if (bus.tail_idx !== 3'd0 || bus.occupancy !== 4'd7 || bus.retire_count !== 4'd1) begin
      miscompares++;
      $display("FAIL full_refuse: got tail=%0d occ=%0d count=%0d expected 0/7/1", bus.tail_idx, bus.occupancy, bus.retire_count);
    end
    step(1, 0, 0, 0);
    vectors++;
    if (bus.tail_idx !== 3'd1 || bus.occupancy !== 4'd8) begin
      miscompares++;
      $display("FAIL full_accept: got tail=%0d occ=%0d expected 1/8", bus.tail_idx, bus.occupancy);
    end
  endtask

  task automatic test_random();
    bit av;
    bit dv;
    bit fl;
    int di;
    step(0, 0, 0, 1);
    for (int c = 0; c < 600; c++) begin
      av = ($urandom_range(0, 99) < 55);
      dv = ($urandom_range(0, 99) < 75);
      fl = ($urandom_range(0, 127) == 0);
      if (order.size() > 0 && $urandom_range(0, 99) < 85)
        di = order[$urandom_range(0, order.size() - 1)];
      else
        di = $urandom_range(0, 7);
      step(av, dv, di, fl);
    end
    repeat (3) step(0, 0, 0, 0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending retires expected 0", sb.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_edge();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
